// File: rtl/seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display: one shared
// decoder, blanked digit slots, double-buffered value swapped at frame boundaries.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic [6:0]            seg_in,
  output logic [3:0]            bin_num,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [4*DIGITS-1:0]  active_reg, active_next;
  logic [4*DIGITS-1:0]  pending_reg, pending_next;
  logic                 pend_v_reg, pend_v_next;
  logic                 frame_next;
  logic [6:0]           seg_next;
  logic [DIGITS-1:0]    an_next;
  logic [3:0]           nib [DIGITS];

  // Outputs are derived from next-state values so that an, seg_out and
  // bin_num line up with the state they describe on the same edge.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]     = active_next[4*gi +: 4];
      assign an_next[gi] = ~((state_next == SHOW) && (idx_next == IDX_W'(gi)) && dig_en[gi]);
    end
  endgenerate

  assign seg_next = (state_next == SHOW) ? seg_in : 7'h7F;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    frame_next = 1'b0;
    case (state_reg)
      BLANK: begin
        if (cnt_reg == BLANK_LAST) state_next = SHOW;
      end
      SHOW: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = BLANK;
          if (idx_reg == IDX_LAST) begin
            idx_next   = '0;
            frame_next = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = BLANK;
    endcase
  end

  // A load landing exactly on the frame boundary goes straight to the
  // active buffer, so it is visible in the very next frame.
  always_comb begin
    active_next  = active_reg;
    pending_next = pending_reg;
    pend_v_next  = pend_v_reg;
    if (frame_next) begin
      pend_v_next = 1'b0;
      if (load) active_next = value;
      else if (pend_v_reg) active_next = pending_reg;
    end else if (load) begin
      pending_next = value;
      pend_v_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= BLANK;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      active_reg  <= '0;
      pending_reg <= '0;
      pend_v_reg  <= 1'b0;
      bin_num     <= 4'h0;
      seg_out     <= 7'h7F;
      an          <= '1;
      frame_done  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      active_reg  <= active_next;
      pending_reg <= pending_next;
      pend_v_reg  <= pend_v_next;
      bin_num     <= nib[idx_next];
      seg_out     <= seg_next;
      an          <= an_next;
      frame_done  <= frame_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles): a
// frame-position model checked every cycle, plus hand-pinned expectations.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dig_en = 4'hF;
  logic [6:0]  seg_in;
  logic [3:0]  bin_num;
  logic [6:0]  seg_out;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dig_en(dig_en),
    .seg_in(seg_in), .bin_num(bin_num), .seg_out(seg_out), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  assign seg_in = seg7(bin_num);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: k_m = edges since reset release; a frame is 32 cycles, slot d is
  // cycles 8d..8d+7 of the frame, first 2 of each slot blank.
  int          k_m;
  logic [15:0] cur_m, pend_m;
  logic        pv_m;
  logic [3:0]  en_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_m <= 0; cur_m <= '0; pend_m <= '0; pv_m <= 1'b0; en_m <= '0;
    end else begin
      k_m  <= k_m + 1;
      en_m <= dig_en;
      if ((k_m + 1) % 32 == 0) begin
        pv_m <= 1'b0;
        if (load) cur_m <= value;
        else if (pv_m) cur_m <= pend_m;
      end else if (load) begin
        pend_m <= value;
        pv_m   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int pos, d, c;
    logic [3:0] nb;
    if (!rst_n) begin
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg_out, 7'h7F);
      chk("rst_bin", bin_num, 0);
      chk("rst_fd", frame_done, 0);
    end else begin
      pos = k_m % 32;
      d = pos / 8;
      c = pos % 8;
      nb = cur_m[d*4 +: 4];
      chk("an", an, (c < 2 || !en_m[d]) ? 4'hF : (~(4'b0001 << d) & 4'hF));
      chk("seg_out", seg_out, (c < 2) ? 7'h7F : seg7(nb));
      chk("bin_num", bin_num, nb);
      chk("frame_done", frame_done, (k_m > 0 && pos == 0) ? 1 : 0);
    end
  end

  task automatic wait_k(input int t);
    for (int i = 0; i < 400 && k_m != t; i++) @(negedge clk);
    chk("wait_k_reached", k_m, t);
  endtask

  int cnt_e, cnt_b, cnt_d, cnt_7;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Scan order after reset with value 0
    wait_k(1);  chk("t1_blank0", an, 4'hF);
    wait_k(2);  chk("t1_dig0", an, 4'hE);
    wait_k(7);  chk("t1_dig0_end", an, 4'hE);
    wait_k(8);  chk("t1_blank1", an, 4'hF);
    wait_k(10); chk("t1_dig1", an, 4'hD);
    wait_k(18); chk("t1_dig2", an, 4'hB);
    wait_k(26); chk("t1_dig3", an, 4'h7);
    wait_k(31); chk("t1_fd_low", frame_done, 0);
    wait_k(32); chk("t1_fd_pulse", frame_done, 1);
    wait_k(33); chk("t1_fd_one", frame_done, 0);

    // Mid-frame load is deferred to the next frame
    wait_k(40); value = 16'h1234; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_k(50); chk("t2_cur_frame", bin_num, 0);
    wait_k(66); chk("t2_dig0", bin_num, 4);
    // Two loads in one frame: last wins
    wait_k(70); value = 16'hAAAA; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_k(75); value = 16'h5555; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_k(90);  chk("t2_dig3", bin_num, 1);
    wait_k(98);  chk("t3_dig0", bin_num, 5);
    wait_k(100); chk("t3_seg5", seg_out, 7'h12);
    wait_k(122); chk("t3_dig3", bin_num, 5);

    // Load in the boundary cycle bypasses the pending buffer
    wait_k(127); value = 16'hBEEF; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_k(130); chk("t4_dig0", bin_num, 4'hF);
    wait_k(138); chk("t4_dig1", bin_num, 4'hE);
    wait_k(154); chk("t4_dig3", bin_num, 4'hB);

    // Disabled digits keep slot timing but never light
    wait_k(159); dig_en = 4'b1010;
    cnt_e = 0; cnt_b = 0; cnt_d = 0; cnt_7 = 0;
    for (int t = 160; t < 192; t++) begin
      wait_k(t);
      if (an == 4'hE) cnt_e++;
      if (an == 4'hB) cnt_b++;
      if (an == 4'hD) cnt_d++;
      if (an == 4'h7) cnt_7++;
    end
    wait_k(192);
    chk("t5_fd", frame_done, 1);
    chk("t5_cnt_e", cnt_e, 0);
    chk("t5_cnt_b", cnt_b, 0);
    chk("t5_cnt_d", cnt_d, 6);
    chk("t5_cnt_7", cnt_7, 6);
    dig_en = 4'hF;

    // Random loads (some on the boundary) and enable changes
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      value = 16'($urandom);
      load = ($urandom_range(0, 7) == 0) || ((k_m % 32 == 31) && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 15) == 0) dig_en = 4'($urandom);
    end
    load = 1'b0;
    value = 16'hC0DE;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    dig_en = 4'hF;

    // Reset asserted asynchronously during SHOW of digit 2
    for (int i = 0; i < 80 && !(k_m % 32 == 20 && k_m > 800); i++) @(negedge clk);
    chk("t6_reached", k_m % 32, 20);
    chk("t6_pre_an", an, 4'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_an", an, 4'hF);
    chk("t6_async_seg", seg_out, 7'h7F);
    chk("t6_async_bin", bin_num, 0);
    @(negedge clk); rst_n = 1'b1;
    wait_k(1); chk("t6_restart_blank", an, 4'hF);
    wait_k(2); chk("t6_restart_dig0", an, 4'hE);
    wait_k(3); chk("t6_active_cleared", bin_num, 0);
    wait_k(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
